// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, R/W bit encoding and ACK/NACK bus levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic ACK          = 1'b0;
  localparam logic NACK         = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings raw SCL/SDA into the clock domain and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync (
  input  logic clk,
  input  logic areset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // [0] metastable stage, [1] synchronised, [2] one cycle older for edge detection
  logic [2:0] scl_p;
  logic [2:0] sda_p;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      scl_p     <= 3'b111;
      sda_p     <= 3'b111;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_s     <= 1'b1;
    end else begin
      scl_p     <= {scl_p[1:0], scl};
      sda_p     <= {sda_p[1:0], sda};
      scl_rise  <= scl_p[1] & ~scl_p[2];
      scl_fall  <= ~scl_p[1] & scl_p[2];
      start_det <= scl_p[1] & scl_p[2] & ~sda_p[1] & sda_p[2];
      stop_det  <= scl_p[1] & scl_p[2] & sda_p[1] & ~sda_p[2];
      sda_s     <= sda_p[1];
    end
  end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with a pointer-addressed byte register file; pointer auto-increments on
// every written or read byte and persists across transactions.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NREGS      = 16,
  localparam int        AW         = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          scl,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_pulse,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] host_raddr,
  output logic [7:0]    host_rdata
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .areset    (areset),
    .scl       (scl),
    .sda       (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_t    state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [6:0]    shreg, shreg_n;
  logic [AW-1:0] ptr, ptr_n;
  logic          rw, rw_n;
  logic          oe_n, busy_n, we;
  logic [7:0]    byte_in;
  logic [7:0]    regs [NREGS];

  assign byte_in    = {shreg, sda_s};
  assign host_rdata = regs[host_raddr];

  // cnt counts bits received (ADDR/PTR/WDATA) or bits already driven (RDATA)
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    ptr_n   = ptr;
    rw_n    = rw;
    oe_n    = sda_oe;
    busy_n  = busy;
    we      = 1'b0;
    if (stop_det) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (start_det) begin
      state_n = ADDR;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise && cnt != 4'd8) begin
            shreg_n = byte_in[6:0];
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              if (state == ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  busy_n = 1'b1;
                  rw_n   = byte_in[0];
                end else begin
                  state_n = WAIT_STOP;
                  busy_n  = 1'b0;
                end
              end else if (state == PTR) begin
                ptr_n = byte_in[AW-1:0];
              end else begin
                we    = 1'b1;
                ptr_n = ptr + 1'b1;
              end
            end
          end else if (scl_fall && cnt == 4'd8) begin
            oe_n  = 1'b1;
            cnt_n = 4'd0;
            if (state == ADDR)     state_n = ADDR_ACK;
            else if (state == PTR) state_n = PTR_ACK;
            else                   state_n = WDATA_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw == I2C_RW_READ) begin
              state_n = RDATA;
              oe_n    = ~regs[ptr][7];
              cnt_n   = 4'd1;
            end else begin
              state_n = PTR;
              oe_n    = 1'b0;
              cnt_n   = 4'd0;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_n = WDATA;
            oe_n    = 1'b0;
            cnt_n   = 4'd0;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              state_n = RDATA_ACK;
              oe_n    = 1'b0;
            end else begin
              oe_n  = ~regs[ptr][~cnt[2:0]];
              cnt_n = cnt + 4'd1;
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            ptr_n   = ptr + 1'b1;
            cnt_n   = 4'd0;
            state_n = (sda_s == ACK) ? RDATA : WAIT_STOP;
          end
        end
        default: oe_n = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      shreg    <= 7'd0;
      ptr      <= '0;
      rw       <= I2C_RW_WRITE;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 8'h00;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      ptr      <= ptr_n;
      rw       <= rw_n;
      sda_oe   <= oe_n;
      busy     <= busy_n;
      wr_pulse <= we;
      if (we) begin
        wr_addr <= ptr;
        wr_data <= byte_in;
      end
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else if (we) begin
      regs[ptr] <= byte_in;
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-level bus master with pull-up, transaction-level register model.
module tb_i2c_reg_target;

  localparam int AW    = 4;
  localparam int NREGS = 16;
  localparam int W     = AW + 8;

  // clock / reset / bus
  logic          clk = 1'b0;
  logic          areset = 1'b0;
  logic          scl = 1'b1;
  logic          m_low = 1'b0;
  logic [AW-1:0] host_raddr = '0;
  logic          sda_line;
  logic          sda_oe, busy, wr_pulse;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data, host_rdata;

  assign sda_line = ~(m_low | sda_oe);

  always #5 clk = ~clk;

  i2c_reg_target #(.SLAVE_ADDR(7'h50), .NREGS(NREGS)) dut (
    .clk        (clk),
    .areset     (areset),
    .scl        (scl),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata)
  );

  // model and scoreboard
  int         checks = 0;
  int         failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;
  logic [7:0] model_regs [NREGS];
  int         model_ptr = 0;
  logic       quiet = 1'b0;
  logic [7:0] tx_buf [8];
  logic [7:0] rd_log [8];
  logic [7:0] prev;
  logic       found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (areset) begin
      if (wr_pulse) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected: got %0h expected none", {wr_addr, wr_data});
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_pulse", {20'd0, wr_addr, wr_data}, {20'd0, exp_e});
        end
      end
      if (quiet) check("quiet_oe", {31'd0, sda_oe}, 32'd0);
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    tick(8); m_low = ~b;
    tick(8); scl = 1'b1;
    tick(8); s = sda_line;
    tick(8); scl = 1'b0;
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      tick(8); m_low = 1'b0;
      tick(8); scl = 1'b1;
    end
    tick(8); m_low = 1'b1;
    tick(8); scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(8); m_low = 1'b1;
    tick(8); scl = 1'b1;
    tick(8); m_low = 1'b0;
    tick(8);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
    bus_bit(ack, s);
  endtask

  // first tx_buf byte is the pointer, the rest are data
  task automatic bus_write(input logic [6:0] addr, input int n);
    logic a;
    logic match;
    match = (addr == 7'h50);
    quiet = ~match;
    bus_start();
    write_byte({addr, 1'b0}, a);
    check("addr_ack", {31'd0, a}, match ? 32'd0 : 32'd1);
    if (match) check("busy_after_addr", {31'd0, busy}, 32'd1);
    else       check("busy_mismatch", {31'd0, busy}, 32'd0);
    for (int i = 0; i < n; i++) begin
      if (match && i > 0) begin
        exp_q.push_back({AW'(model_ptr), tx_buf[i]});
        model_regs[model_ptr] = tx_buf[i];
        model_ptr = (model_ptr + 1) % NREGS;
      end
      write_byte(tx_buf[i], a);
      check("data_ack", {31'd0, a}, match ? 32'd0 : 32'd1);
      if (match && i == 0) model_ptr = int'(tx_buf[0]) % NREGS;
    end
    bus_stop();
    check("busy_after_stop", {31'd0, busy}, 32'd0);
    quiet = 1'b0;
  endtask

  task automatic bus_read(input logic set_ptr, input logic [7:0] p, input int n);
    logic a;
    logic [7:0] got;
    bus_start();
    if (set_ptr) begin
      write_byte(8'hA0, a);
      check("rd_addr_w_ack", {31'd0, a}, 32'd0);
      write_byte(p, a);
      check("rd_ptr_ack", {31'd0, a}, 32'd0);
      model_ptr = int'(p) % NREGS;
      bus_start();
    end
    write_byte(8'hA1, a);
    check("rd_addr_r_ack", {31'd0, a}, 32'd0);
    check("busy_in_read", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, got);
      check("rdata", {24'd0, got}, {24'd0, model_regs[model_ptr]});
      rd_log[i] = got;
      model_ptr = (model_ptr + 1) % NREGS;
    end
    bus_stop();
    check("busy_after_rstop", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_host_all();
    for (int i = 0; i < NREGS; i++) begin
      host_raddr = AW'(i);
      #1;
      check("host_rdata", {24'd0, host_rdata}, {24'd0, model_regs[i]});
    end
  endtask

  task automatic check_host_lit(input int idx, input logic [7:0] v);
    host_raddr = AW'(idx);
    #1;
    check("host_literal", {24'd0, host_rdata}, {24'd0, v});
  endtask

  // main sequence
  initial begin
    logic a, s;
    int kind, n;
    logic [6:0] adr;
    for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
    tick(3);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check_host_all();
    areset = 1'b1;
    tick(20);

    // seed index 5 so a current-address read later proves the pointer landed on 5
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h77;
    bus_write(7'h50, 2);

    tx_buf[0] = 8'h03; tx_buf[1] = 8'h5A; tx_buf[2] = 8'hC3;
    bus_write(7'h50, 3);
    check_host_lit(3, 8'h5A);
    check_host_lit(4, 8'hC3);

    bus_read(1'b1, 8'h03, 2);
    check("lit_rd0", {24'd0, rd_log[0]}, 32'h5A);
    check("lit_rd1", {24'd0, rd_log[1]}, 32'hC3);
    bus_read(1'b0, 8'h00, 1);
    check("lit_cur_ptr5", {24'd0, rd_log[0]}, 32'h77);

    tx_buf[0] = 8'h03; tx_buf[1] = 8'h55;
    bus_write(7'h51, 2);

    tx_buf[0] = 8'h0F; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
    bus_write(7'h50, 3);
    check_host_lit(15, 8'h11);
    check_host_lit(0, 8'h22);

    // STOP four bits into a data byte: pointer set, nothing written
    bus_start();
    write_byte(8'hA0, a);
    check("abort_addr_ack", {31'd0, a}, 32'd0);
    write_byte(8'h07, a);
    check("abort_ptr_ack", {31'd0, a}, 32'd0);
    model_ptr = 7;
    bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b1, s);
    bus_stop();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check_host_lit(7, 8'h00);

    // host port sees the old value until the write edge
    host_raddr = AW'(3);
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h9C;
    found = 1'b0;
    fork
      bus_write(7'h50, 2);
      begin
        prev = host_rdata;
        for (int k = 0; k < 3000 && !found; k++) begin
          @(negedge clk);
          if (wr_pulse) begin
            found = 1'b1;
            check("host_old", {24'd0, prev}, 32'h5A);
            check("host_new", {24'd0, host_rdata}, 32'h9C);
          end else begin
            prev = host_rdata;
          end
        end
        if (!found) begin
          checks++;
          failures++;
          $display("FAIL host_wr_timeout: got no wr_pulse expected one");
        end
      end
    join

    for (int it = 0; it < 15; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        n = $urandom_range(2, 4);
        for (int j = 0; j < n; j++) tx_buf[j] = 8'($urandom_range(0, 255));
        bus_write(7'h50, n);
      end else if (kind == 1) begin
        bus_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom_range(1, 3));
      end else begin
        adr = 7'($urandom_range(0, 127));
        if (adr == 7'h50) adr = 7'h51;
        tx_buf[0] = 8'($urandom_range(0, 255));
        tx_buf[1] = 8'($urandom_range(0, 255));
        bus_write(adr, 2);
      end
    end
    check_host_all();

    // reset in the middle of a read while the target is pulling SDA low
    tx_buf[0] = 8'h08; tx_buf[1] = 8'h00;
    bus_write(7'h50, 2);
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h08, a);
    bus_start();
    write_byte(8'hA1, a);
    check("rst_rd_ack", {31'd0, a}, 32'd0);
    tick(12);
    check("rd_drive_low", {31'd0, sda_oe}, 32'd1);
    areset = 1'b0;
    tick(1);
    check("rst_mid_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    check_host_all();
    m_low = 1'b0;
    scl = 1'b1;
    tick(10);
    areset = 1'b1;
    tick(20);
    bus_read(1'b0, 8'h00, 1);
    check("post_rst_read", {24'd0, rd_log[0]}, 32'h00);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
